// File: rtl/mulacc_feeder.sv
// Operand issue stage: FIFO-buffers a valid/ready stream and presents each head
// operand to the MAC for two enabled cycles (phase 0 multiply, phase 1 commit).
module mulacc_feeder #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hold,
    output logic             mac_en,
    output logic [WIDTH-1:0] mac_x,
    output logic             mac_phase,
    output logic             busy,
    output logic [AW:0]      level,
    output logic [15:0]      issued
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PHASE0 = 2'd1,
        PHASE1 = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic [AW:0]      level_nxt;
    logic [15:0]      issued_q;
    logic             push;
    logic             pop;

    // No write-through: a slot freed by this edge's pop is only offered next cycle.
    assign in_ready  = (level_q != FULL_LEVEL);
    assign push      = in_valid && in_ready;
    assign pop       = (state == PHASE1) && !hold;

    assign busy      = (state != IDLE);
    assign mac_en    = busy && !hold;
    assign mac_phase = (state == PHASE1);
    assign mac_x     = mem[rd_ptr];
    assign level     = level_q;
    assign issued    = issued_q;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level_q - 1'b1;
        end
    end

    // Storage needs no reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            issued_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level_q != '0) begin
                        state <= PHASE0;
                    end
                end
                PHASE0: begin
                    if (!hold) begin
                        state <= PHASE1;
                    end
                end
                PHASE1: begin
                    if (!hold) begin
                        issued_q <= issued_q + 16'd1;
                        // Continue straight into the next operand when one remains.
                        state    <= (level_nxt != '0) ? PHASE0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mulacc_feeder.sv
// Randomized plus directed stimulus; a negedge monitor checks every output
// against an operand queue model built from the stream/phase rules.
module tb_mulacc_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             hold = 1'b0;
    logic             mac_en;
    logic [WIDTH-1:0] mac_x;
    logic             mac_phase;
    logic             busy;
    logic [AW:0]      level;
    logic [15:0]      issued;

    mulacc_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hold      (hold),
        .mac_en    (mac_en),
        .mac_x     (mac_x),
        .mac_phase (mac_phase),
        .busy      (busy),
        .level     (level),
        .issued    (issued)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    int               prev_lvl = 0;
    bit               exp_ph = 1'b0;
    logic [15:0]      exp_issued = '0;
    bit               mon_on = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;
    int               en_cycles = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        int lvl;
        bit exp_busy;
        bit exp_en;
        lvl = exp_q.size();
        // Busy once an operand has sat in the FIFO across an edge, or mid-operand.
        exp_busy = exp_ph || (lvl > 0 && prev_lvl > 0);
        exp_en   = exp_busy && !hold;
        if (mon_on) begin
            chk("level",    32'(level),    32'(lvl));
            chk("in_ready", 32'(in_ready), 32'(lvl < DEPTH));
            chk("busy",     32'(busy),     32'(exp_busy));
            chk("mac_en",   32'(mac_en),   32'(exp_en));
            chk("issued",   32'(issued),   32'(exp_issued));
            if (exp_busy) chk("mac_phase", 32'(mac_phase), 32'(exp_ph));
            if (exp_busy && lvl > 0) chk("mac_x", 32'(mac_x), 32'(exp_q[0]));
            if (exp_en) en_cycles++;
        end
        if (reset) begin
            exp_q.delete();
            exp_ph     = 1'b0;
            exp_issued = '0;
            prev_lvl   = 0;
        end else begin
            if (in_valid && lvl < DEPTH) exp_q.push_back(in_data);
            if (exp_en && exp_ph) begin
                void'(exp_q.pop_front());
                exp_issued = exp_issued + 16'd1;
            end
            if (exp_en) exp_ph = ~exp_ph;
            prev_lvl = lvl;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit h, input bit r);
        in_valid = v;
        in_data  = d;
        hold     = h;
        reset    = r;
    endtask

    initial begin
        logic [WIDTH-1:0] ops [3];
        ops[0] = 8'h02; ops[1] = 8'h03; ops[2] = 8'h04;

        // Reset
        cyc(2);
        mon_on = 1'b1;
        cyc(1);
        drive(0, 8'h00, 0, 0);
        cyc(1);

        // Single operand
        drive(1, 8'h03, 0, 0);
        cyc(1);
        drive(0, 8'h00, 0, 0);
        cyc(6);

        // Back-to-back operands: six contiguous enabled cycles expected
        en_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, ops[i], 0, 0);
            cyc(1);
        end
        drive(0, 8'h00, 0, 0);
        cyc(10);

        // Fill to full under hold, then drain
        for (int i = 0; i < 7; i++) begin
            drive(1, 8'(8'h10 + i), 1, 0);
            cyc(1);
        end
        drive(1, 8'h20, 0, 0);
        cyc(3);
        drive(0, 8'h00, 0, 0);
        cyc(14);

        // Hold raised during phase 1
        drive(1, 8'h5a, 0, 0);
        cyc(1);
        drive(0, 8'h00, 0, 0);
        cyc(2);
        drive(0, 8'h00, 1, 0);
        cyc(3);
        drive(0, 8'h00, 0, 0);
        cyc(4);

        // Reset during phase 1 with three queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h30 + i), 0, 0);
            cyc(1);
        end
        drive(0, 8'h00, 0, 1);
        cyc(1);
        drive(1, 8'h77, 0, 0);
        cyc(1);
        drive(0, 8'h00, 0, 0);
        cyc(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) < 55), 8'($urandom), ($urandom_range(99) < 20),
                  ($urandom_range(999) < 8));
            cyc(1);
        end
        drive(0, 8'h00, 0, 0);
        cyc(12);

        // Issued counter wrap
        drive(0, 8'h00, 1, 0);
        cyc(1);
        force dut.issued_q = 16'hffff;
        exp_issued = 16'hffff;
        #1;
        release dut.issued_q;
        cyc(1);
        drive(1, 8'h99, 0, 0);
        cyc(1);
        drive(0, 8'h00, 0, 0);
        cyc(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
